// File: rtl/axis_out_packer_if.sv
// AXI-Stream beat channel from the output packer toward the accelerator's master port.
interface axis_out_packer_if #(
  parameter int OUT_WIDTH = 64
);
  logic [OUT_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_out_packer.sv
// Buffers unstallable PPU vectors and serializes each into two AXI-Stream beats,
// lower half first, with frame-based tlast and sticky overflow reporting.
module axis_out_packer #(
  parameter int IN_WIDTH        = 128,
  parameter int OUT_WIDTH       = 64,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     i_valid,
  input  logic [IN_WIDTH-1:0]      i_data,
  input  logic                     i_frame_start,
  input  logic [15:0]              cfg_vecs_per_frame,
  axis_out_packer_if.master        m_axis,
  output logic [FIFO_DEPTH_LOG2:0] o_fifo_level,
  output logic                     o_overflow,
  output logic                     o_frame_done,
  output logic                     o_busy
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [IN_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] rd_ptr;
  logic                     half;
  logic [15:0]              cnt;

  logic                     empty;
  logic                     full;
  logic                     beat;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic                     cnt_wrap;
  logic [IN_WIDTH-1:0]      head;

  // Full when pointers differ only in the wrap bit.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
               (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
    beat     = !empty && m_axis.tready;
    pop      = beat && half;
    push     = i_valid && (!full || pop);
    drop     = i_valid && full && !pop;
    cnt_wrap = (cfg_vecs_per_frame != 16'd0) &&
               (cnt == cfg_vecs_per_frame - 16'd1);
  end

  assign head          = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 :
                         (half ? head[OUT_WIDTH +: OUT_WIDTH] : head[0 +: OUT_WIDTH]);
  assign m_axis.tlast  = half && cnt_wrap;
  assign o_fifo_level  = wr_ptr - rd_ptr;
  assign o_busy        = !empty;

  // Storage carries data only; it is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      half         <= 1'b0;
      cnt          <= '0;
      o_overflow   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (beat) half   <= !half;
      // Frame start beats a coincident pop; overflow beats a coincident frame start.
      if (i_frame_start) begin
        cnt <= '0;
      end else if (pop) begin
        cnt <= cnt_wrap ? '0 : cnt + 16'd1;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_frame_start) begin
        o_overflow <= 1'b0;
      end
      o_frame_done <= beat && m_axis.tlast;
    end
  end
endmodule

// File: tb/tb_axis_out_packer.sv
// Directed bench for axis_out_packer with a beat-queue reference model checked every cycle.
module tb_axis_out_packer;
  logic         clk;
  logic         sys_rst_n;
  logic         i_valid;
  logic [127:0] i_data;
  logic         i_frame_start;
  logic [15:0]  cfg_vecs_per_frame;
  logic [3:0]   o_fifo_level;
  logic         o_overflow;
  logic         o_frame_done;
  logic         o_busy;

  axis_out_packer_if #(.OUT_WIDTH(64)) m_axis ();

  axis_out_packer #(
    .IN_WIDTH(128), .OUT_WIDTH(64), .FIFO_DEPTH_LOG2(3)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_frame_start(i_frame_start), .cfg_vecs_per_frame(cfg_vecs_per_frame),
    .m_axis(m_axis), .o_fifo_level(o_fifo_level), .o_overflow(o_overflow),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [127:0] mk(input logic [7:0] i);
    return {56'hA0A0A0A0A0A0A0, i, 56'hB0B0B0B0B0B0B0, i};
  endfunction

  // Reference model: the stream of beats still owed downstream.
  typedef struct packed {
    logic [63:0] d;
    logic        hi;
    logic        last;
  } beat_t;

  beat_t q[$];
  int    m_k;
  bit    m_ovf, m_fd, m_fire, m_pop, m_drop, m_last;
  int    m_lvl;

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      q.delete();
      m_k = 0; m_ovf = 0; m_fd = 0;
    end
    chk("m_tvalid", m_axis.tvalid, q.size() != 0);
    chk("m_tdata",  m_axis.tdata,  (q.size() != 0) ? q[0].d : 64'd0);
    chk("m_tlast",  m_axis.tlast,  (q.size() != 0) ? q[0].last : 1'b0);
    chk("m_level",  o_fifo_level,  (q.size() + 1) / 2);
    chk("m_busy",   o_busy,        q.size() != 0);
    chk("m_ovf",    o_overflow,    m_ovf);
    chk("m_fdone",  o_frame_done,  m_fd);
    if (sys_rst_n) begin
      m_lvl  = (q.size() + 1) / 2;
      m_fire = (q.size() != 0) && m_axis.tready;
      m_pop  = m_fire && q[0].hi;
      m_fd   = m_fire && q[0].last;
      if (m_fire) void'(q.pop_front());
      if (i_frame_start) m_k = 0;
      m_drop = i_valid && (m_lvl == 8) && !m_pop;
      if (i_valid && !m_drop) begin
        m_k++;
        m_last = (cfg_vecs_per_frame != 0) && ((m_k % cfg_vecs_per_frame) == 0);
        q.push_back('{d: i_data[63:0],   hi: 1'b0, last: 1'b0});
        q.push_back('{d: i_data[127:64], hi: 1'b1, last: m_last});
      end
      if (m_drop) m_ovf = 1;
      else if (i_frame_start) m_ovf = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    m_axis.tready = 1'b1;
    for (int c = 0; c < 64 && o_busy; c++) step();
    step();
    chk("drain_idle", o_busy, 1'b0);
  endtask

  task automatic frame_start_pulse();
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
  endtask

  logic [63:0]  got[$];
  logic         lasts[$];
  logic [127:0] v;
  int           nfd;

  initial begin
    sys_rst_n = 1'b1; i_valid = 1'b0; i_data = '0; i_frame_start = 1'b0;
    cfg_vecs_per_frame = 16'd1; m_axis.tready = 1'b0;
    #1 sys_rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_tdata",  m_axis.tdata,  64'd0);
    chk("rst_tlast",  m_axis.tlast,  1'b0);
    chk("rst_level",  o_fifo_level,  4'd0);
    chk("rst_ovf",    o_overflow,    1'b0);
    chk("rst_fdone",  o_frame_done,  1'b0);
    chk("rst_busy",   o_busy,        1'b0);
    step();
    sys_rst_n = 1'b1;
    step();

    // Single vector, cfg=1
    cfg_vecs_per_frame = 16'd1; m_axis.tready = 1'b1;
    i_valid = 1'b1; i_data = {64'h1111111111111111, 64'h2222222222222222};
    step();
    i_valid = 1'b0;
    @(negedge clk);
    chk("single_lat_tvalid", m_axis.tvalid, 1'b1);
    chk("single_lo",         m_axis.tdata,  64'h2222222222222222);
    chk("single_lo_tlast",   m_axis.tlast,  1'b0);
    @(negedge clk);
    chk("single_hi",         m_axis.tdata,  64'h1111111111111111);
    chk("single_hi_tlast",   m_axis.tlast,  1'b1);
    @(negedge clk);
    chk("single_fdone",      o_frame_done,  1'b1);
    chk("single_busy",       o_busy,        1'b0);
    @(negedge clk);
    chk("single_fdone_end",  o_frame_done,  1'b0);
    step();

    // Backpressure holds the lower half
    m_axis.tready = 1'b0;
    i_valid = 1'b1; i_data = mk(8'h33);
    step();
    i_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_tvalid", m_axis.tvalid, 1'b1);
      chk("bp_tdata",  m_axis.tdata,  64'hB0B0B0B0B0B0B033);
      chk("bp_level",  o_fifo_level,  4'd1);
    end
    step();
    drain();

    // Overflow: vector 9 dropped
    cfg_vecs_per_frame = 16'd0; m_axis.tready = 1'b0;
    frame_start_pulse();
    for (int i = 1; i <= 9; i++) begin
      i_valid = 1'b1; i_data = mk(8'(i));
      step();
    end
    i_valid = 1'b0;
    @(negedge clk);
    chk("ovf_level", o_fifo_level, 4'd8);
    chk("ovf_flag",  o_overflow,   1'b1);
    step();
    m_axis.tready = 1'b1;
    got.delete();
    for (int c = 0; c < 60 && got.size() < 16; c++) begin
      @(negedge clk);
      if (m_axis.tvalid) got.push_back(m_axis.tdata);
      step();
    end
    chk("ovf_beats", got.size(), 16);
    for (int j = 0; j < got.size() && j < 16; j++) begin
      v = mk(8'(j / 2 + 1));
      chk("ovf_order", got[j], (j % 2 == 0) ? v[63:0] : v[127:64]);
    end
    @(negedge clk);
    chk("ovf_drained", o_busy, 1'b0);
    step();
    frame_start_pulse();
    @(negedge clk);
    chk("ovf_cleared", o_overflow, 1'b0);
    step();

    // Full FIFO with push on the upper-half handshake
    m_axis.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; i_data = mk(8'(8'hC0 + i));
      step();
    end
    i_valid = 1'b0;
    m_axis.tready = 1'b1;
    step();
    i_valid = 1'b1; i_data = mk(8'hCF);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    chk("full_pp_level", o_fifo_level, 4'd8);
    chk("full_pp_ovf",   o_overflow,   1'b0);
    step();
    drain();

    // Multi-frame tlast, cfg=3, tready toggling
    cfg_vecs_per_frame = 16'd3;
    frame_start_pulse();
    got.delete(); lasts.delete(); nfd = 0;
    for (int c = 0; c < 60; c++) begin
      i_valid = (c < 6);
      i_data = mk(8'(8'h50 + c));
      m_axis.tready = (c % 2 == 0);
      @(negedge clk);
      if (m_axis.tvalid && m_axis.tready) begin
        got.push_back(m_axis.tdata);
        lasts.push_back(m_axis.tlast);
      end
      if (o_frame_done) nfd++;
      step();
    end
    i_valid = 1'b0;
    chk("mf_beats", got.size(), 12);
    for (int j = 0; j < lasts.size(); j++) chk("mf_tlast", lasts[j], (j == 5) || (j == 11));
    chk("mf_fdone_cnt", nfd, 2);
    drain();

    // Reset after lower half of vector 2 of 4
    cfg_vecs_per_frame = 16'd1; m_axis.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = mk(8'(8'h60 + i));
      step();
    end
    i_valid = 1'b0;
    m_axis.tready = 1'b1;
    step(); step(); step();
    sys_rst_n = 1'b0;
    #1;
    chk("arst_tvalid", m_axis.tvalid, 1'b0);
    chk("arst_tdata",  m_axis.tdata,  64'd0);
    chk("arst_tlast",  m_axis.tlast,  1'b0);
    chk("arst_level",  o_fifo_level,  4'd0);
    chk("arst_busy",   o_busy,        1'b0);
    chk("arst_fdone",  o_frame_done,  1'b0);
    step();
    sys_rst_n = 1'b1;
    step();
    i_valid = 1'b1; i_data = mk(8'h70);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lo",       m_axis.tdata, 64'hB0B0B0B0B0B0B070);
    chk("post_rst_lo_tlast", m_axis.tlast, 1'b0);
    @(negedge clk);
    chk("post_rst_hi",       m_axis.tdata, 64'hA0A0A0A0A0A0A070);
    chk("post_rst_hi_tlast", m_axis.tlast, 1'b1);
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
